// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite word-organised SRAM slave with a fixed number of wait states per
// OKAY transfer and the two-cycle ERROR response for illegal accesses.
//
// Parameters
//   DEPTH        number of 32-bit words (1..16384)
//   WAIT_STATES  HREADYOUT-low cycles per OKAY data phase (0..7)
//
// Ports
//   HCLK       in   bus clock, all state updates on the rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select from the address decoder
//   HADDR      in   byte address, only [15:0] decoded
//   HTRANS     in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     in   1 = write
//   HSIZE      in   0 byte, 1 halfword, 2 word, others illegal
//   HWDATA     in   write data, valid in the data phase
//   HREADY     in   multiplexed bus ready
//   HREADYOUT  out  this slave's ready (registered)
//   HRESP      out  0 OKAY, 1 ERROR (registered)
//   HRDATA     out  read data, zero outside a read's final data-phase cycle
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [14:0] DEPTH_W   = 15'(DEPTH);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [2:0]  size_q, size_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;

    logic [31:0] mem [DEPTH];

    logic          accept_s;
    logic          legal_s;
    logic          commit_s;
    logic [3:0]    lanes_s;
    logic [AW-1:0] idx_s;
    logic          unused_s;

    // Transfer is legal when aligned to its size, size is at most a word,
    // and the word index lies inside the array.
    function automatic logic legal_fn(input logic [2:0] size, input logic [15:0] addr);
        logic aligned;
        case (size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~addr[0];
            3'd2:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return aligned && ({1'b0, addr[15:2]} < DEPTH_W);
    endfunction

    // Little-endian byte-lane enables for a legal transfer.
    function automatic logic [3:0] lanes_fn(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] lanes;
        case (size)
            3'd0:    lanes = 4'b0001 << off;
            3'd1:    lanes = off[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

    // Only the low 16 address bits are decoded.
    assign unused_s = ^HADDR[31:16];

    // New address phases can only land while the slave is ready.
    assign accept_s = HSEL && HREADY && HTRANS[1] &&
                      ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2));
    assign legal_s  = legal_fn(HSIZE, HADDR[15:0]);
    assign lanes_s  = lanes_fn(size_q, addr_q[1:0]);
    assign idx_s    = addr_q[AW+1:2];
    assign commit_s = (state_q == S_DONE) && wr_q && !HRESET;

    // Next-state, wait counter, captured address phase and registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        size_d  = size_q;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            S_IDLE:  state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A pipelined accept overrides the fall-back to IDLE.
        if (accept_s) begin
            addr_d = HADDR[15:0];
            wr_d   = HWRITE;
            size_d = HSIZE;
            if (!legal_s) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LOAD;
            end else begin
                state_d = S_DONE;
            end
        end else begin
            addr_d = addr_q;
        end

        hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
        hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 16'd0;
            wr_q        <= 1'b0;
            size_q      <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Byte-lane write commit on the edge that ends a write's DONE cycle.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (commit_s && lanes_s[i]) begin
                mem[idx_s][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // Read data only during a read's DONE cycle, zero otherwise.
    always_comb begin
        if ((state_q == S_DONE) && !wr_q) begin
            HRDATA = mem[idx_s];
        end else begin
            HRDATA = 32'd0;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
// Two slaves on one AHB-Lite bus (WAIT_STATES=0 on select 0, WAIT_STATES=1 on
// select 1). A pipelined master drives directed and random transfers; each
// accepted address phase pushes its expected response, computed from a
// byte-level memory model, and a negedge monitor pops and compares it when
// the data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

    localparam int DEPTH = 1024;
    localparam int WS0   = 0;
    localparam int WS1   = 1;

    logic        clk = 1'b0;
    logic        hreset;
    logic        bus_sel;
    logic        bus_tgt;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        ro0, ro1, rsp0, rsp1;
    logic [31:0] rd0, rd1;
    logic        bus_resp;
    logic [31:0] bus_rdata;
    logic        dp_valid;
    logic        dp_tgt;

    always #5 clk = ~clk;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_ws0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(bus_sel && !bus_tgt), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro0), .HRESP(rsp0), .HRDATA(rd0)
    );

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_ws1 (
        .HCLK(clk), .HRESET(hreset), .HSEL(bus_sel && bus_tgt), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro1), .HRESP(rsp1), .HRDATA(rd1)
    );

    // Response multiplexor selected by the slave owning the data phase.
    assign hready    = !dp_valid ? 1'b1  : (dp_tgt ? ro1 : ro0);
    assign bus_resp  = !dp_valid ? 1'b0  : (dp_tgt ? rsp1 : rsp0);
    assign bus_rdata = !dp_valid ? 32'd0 : (dp_tgt ? rd1 : rd0);

    // Data-phase owner tracking.
    always @(posedge clk) begin
        if (hreset) begin
            dp_valid <= 1'b0;
            dp_tgt   <= 1'b0;
        end else if (hready) begin
            dp_valid <= bus_sel && htrans[1];
            dp_tgt   <= bus_tgt;
        end
    end

    typedef struct {
        bit          tgt;
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          ne;
        bit          fix;
        logic [31:0] fixv;
    } xfer_t;

    typedef struct {
        bit          err;
        bit          ne;
        logic [31:0] data;
        logic [31:0] mask;
        int          waits;
    } exp_t;

    exp_t     sb[$];
    xfer_t    cur;
    int       n_cmp = 0;
    int       n_err = 0;
    bit [31:0] mdata  [2][DEPTH];
    bit [3:0]  mknown [2][DEPTH];
    int       wcnt = 0;
    bit       wbad = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic xfer_t mk(input bit tgt, input bit sel, input logic [1:0] tr, input bit wr,
                                 input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        xfer_t x;
        x.tgt = tgt; x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz;
        x.addr = a; x.wdata = wd; x.ne = 1'b0; x.fix = 1'b0; x.fixv = 32'd0;
        return x;
    endfunction

    function automatic xfer_t mk_rd_fix(input bit tgt, input logic [31:0] a, input logic [31:0] v);
        xfer_t x;
        x = mk(tgt, 1'b1, 2'd2, 1'b0, 3'd2, a, 32'd0);
        x.fix = 1'b1; x.fixv = v;
        return x;
    endfunction

    task automatic present(input xfer_t x);
        cur     = x;
        bus_sel = x.sel;
        bus_tgt = x.tgt;
        htrans  = x.trans;
        hwrite  = x.wr;
        hsize   = x.size;
        haddr   = x.addr;
    endtask

    // Reference model: apply an accepted address phase and queue its response.
    task automatic accept(input xfer_t x);
        exp_t e;
        int   a, w, nb, ba;
        bit   legal;
        if (x.sel && x.trans[1]) begin
            a     = int'(x.addr[15:0]);
            nb    = 1 << x.size;
            w     = a / 4;
            legal = (x.size <= 3'd2) && (a % nb == 0) && (w < DEPTH);
            e.err   = !legal;
            e.ne    = x.ne;
            e.waits = !legal ? 1 : (x.tgt ? WS1 : WS0);
            e.data  = 32'd0;
            e.mask  = (legal && !x.wr) ? 32'd0 : 32'hFFFF_FFFF;
            if (legal) begin
                for (int b = 0; b < 4; b++) begin
                    ba = w * 4 + b;
                    if (x.wr && ba >= a && ba < a + nb) begin
                        mdata[x.tgt][w][8*b +: 8] = x.wdata[8*b +: 8];
                        mknown[x.tgt][w][b] = 1'b1;
                    end
                    if (!x.wr && mknown[x.tgt][w][b]) begin
                        e.data[8*b +: 8] = mdata[x.tgt][w][8*b +: 8];
                        e.mask[8*b +: 8] = 8'hFF;
                    end
                end
            end
            if (x.fix) begin
                e.data = x.fixv;
                e.mask = 32'hFFFF_FFFF;
            end
            sb.push_back(e);
        end
    endtask

    // Wait until the bus is ready, let the edge take the current address
    // phase, then put up the next one and the data for the accepted one.
    task automatic drive(input xfer_t nx);
        int guard = 0;
        @(negedge clk);
        while (!hready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!hready) chk("ready_timeout", 64'(hready), 64'd1);
        @(posedge clk);
        #1;
        accept(cur);
        hwdata = cur.wdata;
        present(nx);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ws0", {ro0, rsp0, rd0}, {1'b1, 1'b0, 32'd0});
        chk("rst_ws1", {ro1, rsp1, rd1}, {1'b1, 1'b0, 32'd0});
    endtask

    // Monitor: idle slaves stay quiet; the owning slave's data phase is
    // compared against the oldest queued expectation when HREADY rises.
    always @(negedge clk) begin
        exp_t e;
        if (hreset) begin
            wcnt = 0;
            wbad = 1'b0;
        end else begin
            if (!(dp_valid && !dp_tgt)) chk("idle_ws0", {ro0, rsp0, rd0}, {1'b1, 1'b0, 32'd0});
            if (!(dp_valid && dp_tgt))  chk("idle_ws1", {ro1, rsp1, rd1}, {1'b1, 1'b0, 32'd0});
            if (dp_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 64'd1, 64'd0);
                end else if (!hready) begin
                    wcnt++;
                    if (bus_resp !== sb[0].err) wbad = 1'b1;
                end else begin
                    e = sb.pop_front();
                    chk("hresp", 64'(bus_resp), 64'(e.err));
                    chk("wait_cycles", 64'(wcnt), 64'(e.waits));
                    chk("wait_hresp", 64'(wbad), 64'd0);
                    if (e.ne) chk("rdata_not_old", 64'(bus_rdata == 32'hDEAD_BEEF), 64'd0);
                    else      chk("rdata", 64'(bus_rdata & e.mask), 64'(e.data & e.mask));
                    wcnt = 0;
                    wbad = 1'b0;
                end
            end
        end
    end

    initial begin
        xfer_t x;
        logic [31:0] r, ra;
        int   guard;

        hreset = 1'b1;
        hwdata = 32'd0;
        present(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0));

        // Power-on reset for two cycles
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 hreset = 1'b0;

        // Reset in the WAIT cycle of a write abandons it
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF));
        drive(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0));
        chk("in_wait", {ro1, rsp1}, {1'b0, 1'b0});
        hreset = 1'b1;
        sb.delete();
        mknown[1][4] = 4'd0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 hreset = 1'b0;
        x = mk(1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0010, 32'd0);
        x.ne = 1'b1;
        drive(x);

        // Word write then back-to-back read
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_0004, 32'h1234_5678));
        drive(mk_rd_fix(1'b1, 32'h0000_0004, 32'h1234_5678));

        // Byte lanes
        r = $urandom;
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_0008, 32'hFFFF_FFFF));
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd0, 32'h0000_000A, {r[31:24], 8'hAA, r[15:0]}));
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd1, 32'h0000_0008, {r[15:0], 16'hBEEF}));
        drive(mk_rd_fix(1'b1, 32'h0000_0008, 32'hFFAA_BEEF));

        // Illegal accesses leave memory untouched
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_0000, 32'h0BAD_F00D));
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_0002, 32'h1111_1111));
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd3, 32'h0000_0000, 32'h2222_2222));
        drive(mk(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h0000_1000, 32'h3333_3333));
        drive(mk(1'b0, 1'b1, 2'd2, 1'b0, 3'd1, 32'h0000_0001, 32'd0));
        drive(mk_rd_fix(1'b1, 32'h0000_0000, 32'h0BAD_F00D));
        drive(mk_rd_fix(1'b1, 32'h0000_0008, 32'hFFAA_BEEF));

        // Non-transfers: IDLE, BUSY, deselected NONSEQ
        drive(mk(1'b1, 1'b1, 2'd0, 1'b1, 3'd2, 32'h0000_0004, $urandom));
        drive(mk(1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 32'h0000_0004, $urandom));
        drive(mk(1'b1, 1'b0, 2'd2, 1'b1, 3'd2, 32'h0000_0004, $urandom));
        drive(mk_rd_fix(1'b1, 32'h0000_0004, 32'h1234_5678));

        // Zero-wait burst on the WAIT_STATES=0 slave
        for (int i = 0; i < 4; i++) drive(mk(1'b0, 1'b1, 2'd2, 1'b1, 3'd2, 32'(4 * i), $urandom));
        drive(mk(1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h0000_0000, 32'd0));
        for (int i = 1; i < 4; i++) drive(mk(1'b0, 1'b1, 2'd3, 1'b0, 3'd2, 32'(4 * i), 32'd0));

        // Randomised traffic to both slaves
        for (int n = 0; n < 400; n++) begin
            r  = $urandom;
            ra = $urandom;
            x.tgt   = r[0];
            x.sel   = (r[3:1] != 3'd0);
            x.trans = r[5:4];
            x.wr    = r[6];
            x.size  = (r[11:8] == 4'd0) ? 3'd3 : 3'(r[13:12] % 2'd3);
            if (r[17:14] == 4'd0) x.addr = ra;
            else                  x.addr = {ra[31:16], 10'd0, ra[5:0]};
            x.wdata = $urandom;
            x.ne    = 1'b0;
            x.fix   = 1'b0;
            x.fixv  = 32'd0;
            drive(x);
        end

        // Drain
        drive(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0));
        drive(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0));
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite memory slave with a configurable number of wait states. One instance occupies one select line of the bus. It drives the HRDATAx / HRESPx / HREADYOUTx inputs of the slave-to-master response multiplexor and receives the multiplexed HREADY back. It implements a word-organised SRAM with byte/halfword/word writes, a fixed wait-state count per transfer, and the two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; legal range 1..16384.
- WAIT_STATES, 1: HREADYOUT-low cycles inserted in every OKAY data phase; legal range 0..7.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  reset; one clock, synchronous, active-high.
- HSEL  in  1  select from the address decoder.
- HADDR  in  32  byte address. Only HADDR[15:0] is decoded (64 KiB window).
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 byte, 1 halfword, 2 word; values above 2 are illegal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  multiplexed bus ready.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

## Operation
- **Address phase accept:** an address phase is accepted on an edge where HSEL=1, HREADY=1 and HTRANS[1]=1.
- **IDLE/BUSY or HSEL=0:** no data phase is started. On an accept edge, capture HADDR[15:0], HWRITE and HSIZE into addr_q, wr_q and size_q.
- **Legality check:** the transfer is illegal, and receives ERROR, if any of these hold:
  - HSIZE > 2;
  - misaligned (HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]≠0);
  - HADDR[15:2] ≥ DEPTH.
- **States:**
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0. A counter loads WAIT_STATES−1 on entry and decrements each cycle.
  - DONE: HREADYOUT=1, HRESP=0; final data-phase cycle.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- **Transitions on a legal accept:**
  - go to WAIT if WAIT_STATES>0, else DONE;
  - WAIT goes to DONE when the counter reaches 0.
- **Transitions on an illegal accept:** go to ERR1, then ERR2 (always exactly one cycle each).
- **Leaving DONE or ERR2:** go to the accept state (WAIT, DONE or ERR1) if a new accept occurs on that edge (pipelined back-to-back transfer), else IDLE.
- **No new accepts during WAIT or ERR1:** HREADY is low, so none occur.
- **Write commit:** on the edge ending DONE, when wr_q=1. Write byte lanes are derived from size_q and addr_q[1:0] (little-endian):
  - byte: lane addr_q[1:0];
  - halfword: lanes {addr_q[1],0} and {addr_q[1],1};
  - word: all four lanes.
  - Unselected bytes are untouched.
  - ERROR transfers never write.
- **Read data:** HRDATA = mem[addr_q[15:2]] (full word, all lanes) while state is DONE and wr_q=0; otherwise HRDATA = 0.
- **Memory reset:** memory contents are not reset and are undefined until written.

## Timing
- **Reset values:** while HRESET=1 and on the following cycle: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0.
- **Reset mid-transfer:** abandons the transfer; a pending write is not committed.
- **Latency:** address phase at edge N → data phase spans cycles N+1 … N+1+WAIT_STATES. HREADYOUT is high only in the last of these cycles.
  - WAIT_STATES=0: single-cycle data phase.
- **ERROR:** exactly 2 data-phase cycles regardless of WAIT_STATES. HRESP=1 in both; HREADYOUT is 0 then 1.
- **Read-after-write, same address, back-to-back:** the write commits on the same edge that accepts the read address. The read's DONE cycle therefore returns the new data; no forwarding is needed.
- **Outputs:** HREADYOUT and HRESP are pure functions of the registered state (no combinational path from inputs). HRDATA is combinational from the registered address and memory only.

## Test plan
1. **Reset behaviour:** assert HRESET for 2 cycles mid-WAIT of a write of 0xDEADBEEF to 0x0010 → HREADYOUT=1, HRESP=0, HRDATA=0; a later read of 0x0010 does not return 0xDEADBEEF.
2. **Word write then read:** WAIT_STATES=1; write word 0x12345678 to 0x0004, then read 0x0004 back-to-back → each data phase shows HREADYOUT 0 then 1; read returns 0x12345678 in the DONE cycle.
3. **Byte lanes:** word 0xFFFFFFFF at 0x0008; byte write 0xAA at 0x000A; halfword write 0xBEEF at 0x0008 (value on lanes 1:0) → read 0x0008 returns 0xFFAABEEF.
4. **Illegal accesses:**
   - HSIZE=2 at 0x0002 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1);
   - same for HSIZE=3;
   - same for address DEPTH*4 (DEPTH=1024 → 0x1000);
   - memory unchanged in all cases.
5. **Non-transfers:** IDLE, BUSY, and HSEL=0 with HTRANS=NONSEQ, each while HREADY=1 → no state change, HREADYOUT stays 1, no write.
6. **Zero-wait burst:** WAIT_STATES=0; four SEQ reads of 0x0000..0x000C issued every cycle → HREADYOUT constantly 1, data returned one cycle after each address.
